// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the multi-read-port register bank.
package reg_bank_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } rb_state_t;

   function automatic int depth(input int addr_w);
      return 1 << addr_w;
   endfunction

   // Low bit of port `port` inside a flat bus of `w`-bit fields.
   function automatic int slice_lo(input int port, input int w);
      return port * w;
   endfunction

   function automatic int slice_hi(input int port, input int w);
      return port * w + w - 1;
   endfunction

endpackage

// File: rtl/reg_bank_mp_if.sv
// Decode/writeback bus of the register bank; the bank is the slave side.
interface reg_bank_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                       ready;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic [NUM_RD-1:0]          rd_busy;
   logic                       wr_en;
   logic [ADDR_W-1:0]          wr_addr;
   logic [DATA_W-1:0]          wr_data;
   logic                       rsv_en;
   logic [ADDR_W-1:0]          rsv_addr;

   modport master (
      input  ready, rd_data, rd_busy,
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr
   );

   modport slave (
      output ready, rd_data, rd_busy,
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr
   );
endinterface

// File: rtl/reg_bank_clr_seq.sv
// Post-reset clear sequencer: walks every register address once, then raises ready.
module reg_bank_clr_seq
   import reg_bank_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   rb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == '1) state_d = READY;
      end
   end

   // The clear write is held off on the reset edge itself so contents survive it.
   always_comb begin
      ready    = (state_q == READY);
      clr_we   = (state_q == CLEAR) && !rst;
      clr_addr = clr_cnt_q;
   end

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-read-port register bank with write forwarding, zero register and busy scoreboard.
module reg_bank_mp
   import reg_bank_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic          clk,
   input logic          rst,
   reg_bank_mp_if.slave bus
);

   localparam int DEPTH = depth(ADDR_W);

   logic              ready;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_ok, rsv_ok;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;

   reg_bank_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign bus.ready = ready;
   assign wr_ok  = ready && bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
   assign rsv_ok = ready && bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

   always_comb begin
      regs_d = regs_q;
      if (clr_we) regs_d[clr_addr] = '0;
      if (wr_ok)  regs_d[bus.wr_addr] = bus.wr_data;
   end

   // Reservation is applied after the release so a same-edge reserve keeps the bit set.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok)  busy_d[bus.wr_addr]  = 1'b0;
      if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      localparam int ALO = slice_lo(i, ADDR_W);
      localparam int AHI = slice_hi(i, ADDR_W);
      localparam int DLO = slice_lo(i, DATA_W);
      localparam int DHI = slice_hi(i, DATA_W);

      logic [ADDR_W-1:0] ra;
      logic              is_zero;
      logic              wr_hit;
      logic [DATA_W-1:0] rd_val;
      logic              busy_val;

      assign ra      = bus.rd_addr[AHI:ALO];
      assign is_zero = (ZERO_REG != 0) && (ra == '0);
      assign wr_hit  = bus.wr_en && (bus.wr_addr == ra);

      always_comb begin
         rd_val = regs_q[ra];
         if ((BYPASS != 0) && wr_hit) rd_val = bus.wr_data;
         if (is_zero || !ready) rd_val = '0;
      end

      assign busy_val           = ready && !is_zero && busy_q[ra] && !wr_hit;
      assign bus.rd_data[DHI:DLO] = rd_val;
      assign bus.rd_busy[i]     = busy_val;
   end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp: a 4-port bypassing bank and a 2-port non-bypassing bank.
module tb_reg_bank_mp;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   n;

   reg_bank_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) ifa ();
   reg_bank_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

   reg_bank_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   reg_bank_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       nm;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [4:0]  ra;
      logic [4:0]  rd [4];
      logic [31:0] ed [4];
      logic [3:0]  eb;
   } vec_t;

   typedef struct {
      string       nm;
      int          port;
      logic [31:0] d;
      logic        b;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void add(input string nm, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic re, input logic [4:0] ra,
                               input logic [4:0] r0, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] r3,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input logic [3:0] eb);
      vec_t v;
      v.nm = nm; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
      v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2; v.rd[3] = r3;
      v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2; v.ed[3] = d3;
      v.eb = eb;
      vecs.push_back(v);
   endfunction

   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      ifa.wr_en    = v.we;
      ifa.wr_addr  = v.wa;
      ifa.wr_data  = v.wd;
      ifa.rsv_en   = v.re;
      ifa.rsv_addr = v.ra;
      ifa.rd_addr  = {v.rd[3], v.rd[2], v.rd[1], v.rd[0]};
      for (int p = 0; p < 4; p++) begin
         e.nm = v.nm; e.port = p; e.d = v.ed[p]; e.b = v.eb[p];
         exp_q.push_back(e);
      end
      #2;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("%s_data%0d", e.nm, e.port), ifa.rd_data[e.port*32 +: 32], e.d);
         check($sformatf("%s_busy%0d", e.nm, e.port), {31'd0, ifa.rd_busy[e.port]}, {31'd0, e.b});
      end
   endtask

   task automatic idle_a();
      ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
      ifa.rsv_en = 1'b0; ifa.rsv_addr = '0; ifa.rd_addr = '0;
   endtask

   // Counts rising edges after reset release until ready is seen high.
   task automatic wait_ready(output int cnt);
      for (cnt = 1; cnt <= 200; cnt++) begin
         @(posedge clk);
         #1;
         if (ifa.ready) break;
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_a();
      ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
      ifb.rsv_en = 1'b0; ifb.rsv_addr = '0; ifb.rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ifa.ready}, 32'd0);
      check("rst_busy", {28'd0, ifa.rd_busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_ready(n);
      check("clear_latency0", n, 32);

      // Put a nonzero value in reg 31, then reset and confirm the clear wipes it.
      @(negedge clk);
      ifa.wr_en = 1'b1; ifa.wr_addr = 5'd31; ifa.wr_data = 32'd7;
      @(negedge clk);
      idle_a();
      ifa.rd_addr = {5'd0, 5'd0, 5'd0, 5'd31};
      #2;
      check("preload31", ifa.rd_data[31:0], 32'd7);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst2_ready", {31'd0, ifa.ready}, 32'd0);
      check("clear_rd31", ifa.rd_data[31:0], 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_ready(n);
      check("clear_latency1", n, 32);
      check("ready_b", {31'd0, ifb.ready}, 32'd1);
      @(negedge clk);
      #2;
      check("after_clear31", ifa.rd_data[31:0], 32'd0);

      add("wr3_byp",  1, 3, 32'h9,       0, 0, 3, 0, 0, 0, 32'h9, 0, 0, 0, 4'b0000);
      add("rd3_hold", 0, 0, 0,           0, 0, 3, 3, 0, 0, 32'h9, 32'h9, 0, 0, 4'b0000);
      add("zero_wr",  1, 0, 32'hFFFFFFFF,0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
      add("zero_rsv", 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
      add("zero_aft", 0, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
      add("rsv5",     0, 0, 0,           1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
      add("busy5",    0, 0, 0,           0, 0, 5, 5, 0, 0, 0, 0, 0, 0, 4'b0011);
      add("wr5_rel",  1, 5, 32'h55,      0, 0, 5, 3, 0, 0, 32'h55, 32'h9, 0, 0, 4'b0000);
      add("after5",   0, 0, 0,           0, 0, 5, 0, 0, 0, 32'h55, 0, 0, 0, 4'b0000);
      add("rsvwr8",   1, 8, 32'hA5A5,    1, 8, 8, 0, 0, 0, 32'hA5A5, 0, 0, 0, 4'b0000);
      add("busy8",    0, 0, 0,           0, 0, 8, 8, 0, 0, 32'hA5A5, 32'hA5A5, 0, 0, 4'b0011);
      add("rersv8",   0, 0, 0,           1, 8, 8, 0, 0, 0, 32'hA5A5, 0, 0, 0, 4'b0001);
      add("still8",   0, 0, 0,           0, 0, 8, 5, 0, 0, 32'hA5A5, 32'h55, 0, 0, 4'b0001);
      add("wr1",      1, 1, 32'd2,       0, 0, 1, 0, 0, 0, 32'd2, 0, 0, 0, 4'b0000);
      add("wr2",      1, 2, 32'd3,       0, 0, 2, 0, 0, 0, 32'd3, 0, 0, 0, 4'b0000);
      add("wr3",      1, 3, 32'd4,       0, 0, 3, 0, 0, 0, 32'd4, 0, 0, 0, 4'b0000);
      add("wr4",      1, 4, 32'd5,       0, 0, 4, 0, 0, 0, 32'd5, 0, 0, 0, 4'b0000);
      add("mp_1234",  0, 0, 0,           0, 0, 1, 2, 3, 4, 32'd2, 32'd3, 32'd4, 32'd5, 4'b0000);
      add("mp_2222",  0, 0, 0,           0, 0, 2, 2, 2, 2, 32'd3, 32'd3, 32'd3, 32'd3, 4'b0000);
      add("wr8_rel",  1, 8, 32'h77,      0, 0, 8, 8, 8, 8, 32'h77, 32'h77, 32'h77, 32'h77, 4'b0000);
      add("after8",   0, 0, 0,           0, 0, 8, 0, 0, 0, 32'h77, 0, 0, 0, 4'b0000);

      foreach (vecs[k]) apply(vecs[k]);
      @(negedge clk);
      idle_a();

      // Without forwarding, a same-cycle read sees the old value.
      ifb.wr_en = 1'b1; ifb.wr_addr = 5'd3; ifb.wr_data = 32'h9; ifb.rd_addr = {5'd0, 5'd3};
      #2;
      check("nobyp_same", ifb.rd_data[31:0], 32'd0);
      @(negedge clk);
      ifb.wr_en = 1'b0;
      #2;
      check("nobyp_next", ifb.rd_data[31:0], 32'd9);

      // Reset again partway through the clear, then attempt writes while not ready.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midclr_ready", {31'd0, ifa.ready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (ifa.ready) break;
         @(negedge clk);
         if (n >= 20) begin
            ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'hDEAD;
            ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd3;
            ifa.rd_addr = {5'd0, 5'd0, 5'd0, 5'd3};
         end
         if (n == 25) begin
            #2;
            check("clr_rd_data", ifa.rd_data[31:0], 32'd0);
            check("clr_rd_busy", {31'd0, ifa.rd_busy[0]}, 32'd0);
         end
      end
      check("clear_latency2", n, 32);
      @(negedge clk);
      idle_a();
      ifa.rd_addr = {5'd0, 5'd1, 5'd8, 5'd3};
      #2;
      check("post_clr_r3", ifa.rd_data[31:0], 32'd0);
      check("post_clr_b3", {31'd0, ifa.rd_busy[0]}, 32'd0);
      check("post_clr_r8", ifa.rd_data[63:32], 32'd0);
      check("post_clr_r1", ifa.rd_data[95:64], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
